// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU control encodings and condition-code bit positions.
// Also used by the control unit so both stages agree on the encoding.
package alu_exec_stage_pkg;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_MOV  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_RLC  = 4'b0110;
    localparam logic [3:0] ALU_RRC  = 4'b0111;
    localparam logic [3:0] ALU_SETC = 4'b1000;
    localparam logic [3:0] ALU_CLRC = 4'b1001;
    localparam logic [3:0] ALU_NOT  = 4'b1010;
    localparam logic [3:0] ALU_NEG  = 4'b1011;
    localparam logic [3:0] ALU_INC  = 4'b1100;
    localparam logic [3:0] ALU_DEC  = 4'b1101;

    localparam int unsigned CCR_Z = 0;
    localparam int unsigned CCR_N = 1;
    localparam int unsigned CCR_C = 2;
    localparam int unsigned CCR_V = 3;

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU: result, candidate flags and the mask of flags the op writes.
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_ctrl,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       flag_mask
);

    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;
    logic [WIDTH:0] neg_w;

    always_comb begin
        add_w = {1'b0, op_a} + {1'b0, op_b};
        sub_w = {1'b0, op_a} - {1'b0, op_b};
        inc_w = {1'b0, op_b} + {{WIDTH{1'b0}}, 1'b1};
        dec_w = {1'b0, op_b} - {{WIDTH{1'b0}}, 1'b1};
        neg_w = {(WIDTH+1){1'b0}} - {1'b0, op_b};

        result    = '0;
        flags     = '0;
        flag_mask = '0;

        unique case (alu_ctrl)
            ALU_MOV: result = op_b;
            ALU_ADD: begin
                result         = add_w[WIDTH-1:0];
                flags[CCR_C]   = add_w[WIDTH];
                flags[CCR_V]   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
                flag_mask      = 4'b1111;
            end
            ALU_SUB: begin
                result         = sub_w[WIDTH-1:0];
                flags[CCR_C]   = sub_w[WIDTH];
                flags[CCR_V]   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
                flag_mask      = 4'b1111;
            end
            ALU_AND: begin
                result    = op_a & op_b;
                flag_mask = 4'b0011;
            end
            ALU_OR: begin
                result    = op_a | op_b;
                flag_mask = 4'b0011;
            end
            ALU_RLC: begin
                result       = {op_b[WIDTH-2:0], carry_in};
                flags[CCR_C] = op_b[WIDTH-1];
                flag_mask    = 4'b0100;
            end
            ALU_RRC: begin
                result       = {carry_in, op_b[WIDTH-1:1]};
                flags[CCR_C] = op_b[0];
                flag_mask    = 4'b0100;
            end
            ALU_SETC: begin
                flags[CCR_C] = 1'b1;
                flag_mask    = 4'b0100;
            end
            ALU_CLRC: flag_mask = 4'b0100;
            ALU_NOT: begin
                result    = ~op_b;
                flag_mask = 4'b0011;
            end
            ALU_NEG: begin
                result    = neg_w[WIDTH-1:0];
                flag_mask = 4'b0011;
            end
            ALU_INC: begin
                result       = inc_w[WIDTH-1:0];
                flags[CCR_C] = inc_w[WIDTH];
                flags[CCR_V] = !op_b[WIDTH-1] && inc_w[WIDTH-1];
                flag_mask    = 4'b1111;
            end
            ALU_DEC: begin
                result       = dec_w[WIDTH-1:0];
                flags[CCR_C] = dec_w[WIDTH];
                flags[CCR_V] = op_b[WIDTH-1] && !dec_w[WIDTH-1];
                flag_mask    = 4'b1111;
            end
            default: ;
        endcase

        flags[CCR_Z] = (result == '0);
        flags[CCR_N] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU, EX/MEM pipeline register, condition-code register and its shadow.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       in_rd,
    input  logic             in_wb_en,
    input  logic             stall,
    input  logic             flush,
    input  logic             ccr_save,
    input  logic             ccr_restore,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       out_rd,
    output logic             out_wb_en,
    output logic [3:0]       ccr
);

    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [3:0]       alu_mask;
    logic [3:0]       shadow;
    logic             commit;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_ctrl  (alu_ctrl),
        .carry_in  (ccr[CCR_C]),
        .result    (alu_result),
        .flags     (alu_flags),
        .flag_mask (alu_mask)
    );

    always_comb begin
        commit = in_valid && !stall && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_rd    <= '0;
            out_wb_en <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wb_en <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            result    <= alu_result;
            out_rd    <= in_rd;
            out_wb_en <= in_wb_en && in_valid;
        end
    end

    // Shadow samples the pre-edge CCR, so a save alongside a committing op keeps the old flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr    <= '0;
            shadow <= '0;
        end else begin
            if (ccr_restore) begin
                ccr <= shadow;
            end else if (commit) begin
                ccr <= (ccr & ~alu_mask) | (alu_flags & alu_mask);
            end
            if (ccr_save && !ccr_restore) begin
                shadow <= ccr;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed checks of alu_exec_stage against an arithmetic reference model.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] alu_ctrl;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] in_rd;
    logic       in_wb_en;
    logic       stall;
    logic       flush;
    logic       ccr_save;
    logic       ccr_restore;
    logic       out_valid;
    logic [7:0] result;
    logic [1:0] out_rd;
    logic       out_wb_en;
    logic [3:0] ccr;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    bit       m_valid;
    bit       m_wb;
    int       m_result;
    int       m_rd;
    bit [3:0] m_ccr;
    bit [3:0] m_shadow;

    alu_exec_stage #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .in_rd       (in_rd),
        .in_wb_en    (in_wb_en),
        .stall       (stall),
        .flush       (flush),
        .ccr_save    (ccr_save),
        .ccr_restore (ccr_restore),
        .out_valid   (out_valid),
        .result      (result),
        .out_rd      (out_rd),
        .out_wb_en   (out_wb_en),
        .ccr         (ccr)
    );

    always #5 clk = ~clk;

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        check("result",    result,            8'(m_result));
        check("out_rd",    {6'd0, out_rd},    8'(m_rd));
        check("out_wb_en", {7'd0, out_wb_en}, {7'd0, m_wb});
        check("ccr",       {4'd0, ccr},       {4'd0, m_ccr});
    endtask

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_result = 0; m_rd = 0; m_ccr = 0; m_shadow = 0;
    endtask

    task automatic do_reset(input bit with_stall);
        rst = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 8'h12; op_b = 8'h34;
        in_rd = 2'd3; in_wb_en = 1'b1; stall = with_stall; flush = 1'b0;
        ccr_save = 1'b1; ccr_restore = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic step(input bit v, input int op, input int a, input int b, input int rd,
                        input bit wb, input bit st, input bit fl, input bit sv, input bit rs);
        int  r;
        bit  z, n, c, ov;
        bit  [3:0] old_ccr;
        in_valid = v; alu_ctrl = 4'(op); op_a = 8'(a); op_b = 8'(b); in_rd = 2'(rd);
        in_wb_en = wb; stall = st; flush = fl; ccr_save = sv; ccr_restore = rs;
        @(posedge clk);
        old_ccr = m_ccr;
        ov = m_ccr[3]; c = m_ccr[2]; n = m_ccr[1]; z = m_ccr[0];
        r = 0;
        case (op)
            1:  r = b;
            2:  begin r = a + b; c = (r > 255); ov = (sx(a) + sx(b) > 127) || (sx(a) + sx(b) < -128); end
            3:  begin r = a - b; c = (a < b);   ov = (sx(a) - sx(b) > 127) || (sx(a) - sx(b) < -128); end
            4:  r = a & b;
            5:  r = a | b;
            6:  begin r = b * 2 + int'(old_ccr[2]); c = (b >= 128); end
            7:  begin r = int'(old_ccr[2]) * 128 + b / 2; c = (b % 2 == 1); end
            8:  c = 1;
            9:  c = 0;
            10: r = 255 - b;
            11: r = 256 - b;
            12: begin r = b + 1; c = (r > 255); ov = (sx(b) + 1 > 127); end
            13: begin r = b - 1; c = (b == 0);  ov = (sx(b) - 1 < -128); end
            default: r = 0;
        endcase
        r = ((r % 256) + 256) % 256;
        if (op inside {2, 3, 4, 5, 10, 11, 12, 13}) begin
            z = (r == 0);
            n = (r >= 128);
        end
        if (rs)
            m_ccr = m_shadow;
        else if (v && !st && !fl)
            m_ccr = {ov, c, n, z};
        if (sv && !rs)
            m_shadow = old_ccr;
        if (fl) begin
            m_valid = 0; m_wb = 0;
        end else if (!st) begin
            m_valid = v; m_result = r; m_rd = rd; m_wb = v && wb;
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        do_reset(1'b0);

        // ADD overflow into sign, then carry-out wrap to zero
        step(1, 2, 8'h7F, 8'h01, 1, 1, 0, 0, 0, 0);
        check("add_7f_ccr", {4'd0, ccr}, 8'h0A);
        step(1, 2, 8'hFF, 8'h01, 2, 1, 0, 0, 0, 0);
        check("add_ff_ccr", {4'd0, ccr}, 8'h05);

        // Rotates through carry
        step(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 6, 0, 8'h80, 1, 1, 0, 0, 0, 0);
        check("rlc_result", result, 8'h01);
        step(1, 7, 0, 8'h01, 1, 1, 0, 0, 0, 0);
        check("rrc_result", result, 8'h80);

        // Borrow cases and NEG leaving C alone
        step(1, 3, 8'h03, 8'h05, 0, 1, 0, 0, 0, 0);
        step(1, 13, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 11, 0, 8'h01, 3, 1, 0, 0, 0, 0);

        // Stall three cycles, then commit; then stall+flush squash
        for (int i = 0; i < 3; i++)
            step(1, 2, 8'h10, 8'h20, 2, 1, 1, 0, 0, 0);
        step(1, 2, 8'h10, 8'h20, 2, 1, 0, 0, 0, 0);
        step(1, 2, 8'h10, 8'h20, 2, 1, 1, 1, 0, 0);

        // Save 0101, disturb flags, restore alongside a committing ADD
        step(1, 2, 8'hFF, 8'h01, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4, 8'hF0, 8'h80, 1, 1, 0, 0, 0, 0);
        step(1, 2, 8'h7F, 8'h7F, 1, 1, 0, 0, 0, 1);
        check("restore_ccr", {4'd0, ccr}, 8'h05);

        // Undefined codes behave as NOP but still write back
        step(1, 14, 8'h55, 8'hAA, 2, 1, 0, 0, 0, 0);
        step(1, 15, 8'h55, 8'hAA, 3, 1, 0, 0, 0, 0);

        // Reset while stalled discards the in-flight instruction
        step(1, 2, 8'h01, 8'h02, 1, 1, 1, 0, 0, 0);
        do_reset(1'b1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
